vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port video-RAM arbiter between the CPU's `WVM` write path and the VGA scan-out fetch, plus an optional hardware fill engine.
- Sits between the processor execute stage and the 1024×3-bit video RAM (32×32 cells, 3-bit colour).
- Grants at most one RAM access per cycle.
- Buffers CPU writes in a small FIFO so scan-out never stalls.

## Interface
Parameters:
- ADDR_W, 10, video RAM address width (1024 cells)
- DATA_W, 3, colour width
- FIFO_DEPTH, 4, CPU write FIFO entries (power of two)

Ports:
- Clock  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- iCpuWrEn  in  1  one-cycle write request (`WVM`)
- iCpuWrAddr  in  ADDR_W  write address
- iCpuWrData  in  DATA_W  write colour
- oCpuBusy  out  1  CPU must stall; write requests are ignored while high
- iVgaRdEn  in  1  scan-out fetch request
- iVgaRdAddr  in  ADDR_W  fetch address
- oVgaRdData  out  DATA_W  fetched colour, equal to iRamRdData
- oVgaRdValid  out  1  oVgaRdData valid this cycle
- iFillStart  in  1  one-cycle fill request
- iFillColor  in  DATA_W  fill colour, latched on accepted start
- oFillBusy  out  1  fill pending or in progress
- oRamAddr  out  ADDR_W  RAM address
- oRamWrEn  out  1  RAM write strobe
- oRamWrData  out  DATA_W  RAM write data
- iRamRdData  in  DATA_W  RAM read data, valid one cycle after the address

## Operation
- **Priority (fixed, per cycle):** VGA read > FIFO head write > fill write. Exactly one grant or none.
- **RAM port outputs** are combinational from the current grant.
  - oRamWrEn=0 when the grant is a VGA read or there is no grant.
  - oRamAddr=0 when there is no grant.
- **FIFO:** circular buffer with ADDR_W+DATA_W-bit entries and registered count.
  - Push when iCpuWrEn && !oCpuBusy.
  - Pop when the head write is granted.
  - Simultaneous push and pop leaves the count unchanged.
- **oCpuBusy** = (count==FIFO_DEPTH) || oFillBusy.
  - A push in the same cycle as a pop while full is rejected; full is evaluated on the registered count.
- **Write ordering:** CPU writes reach RAM in issue order. Two writes to the same address: the last one wins.
- **Fill FSM:** IDLE, DRAIN, FILL.
  - IDLE: iFillStart latches the colour, clears the address counter to 0, and moves to DRAIN. Starts in any other state are ignored.
  - DRAIN: waits for count==0, then moves to FILL.
  - FILL: writes the colour to the counter address whenever neither VGA nor FIFO owns the port, then increments the counter.
  - After the write to address 1023 (counter wraps to 0), return to IDLE.
- oFillBusy=1 in DRAIN and FILL.
- Because oCpuBusy is high throughout the fill, no CPU write interleaves with it.

## Timing
- **Reset values:** FIFO empty; FSM IDLE; fill counter 0.
  - oCpuBusy=0, oFillBusy=0, oVgaRdValid=0, oRamWrEn=0.
  - Fill colour register cleared to 0.
- **VGA read latency:** request in cycle N gives oVgaRdValid=1 in N+1, with oVgaRdData=iRamRdData. Back-to-back reads are supported at one per cycle.
- **CPU write latency:** a push in cycle N is earliest on the RAM port in N+1. It is delayed one cycle for every cycle with iVgaRdEn=1 and every older entry ahead of it.
- **oCpuBusy** rises the cycle after the push that fills the FIFO. It falls the cycle after the pop that frees a slot.
- **oFillBusy** rises the cycle after an accepted start. It falls the cycle after the 1024th fill write.
  - Minimum fill duration, with an empty FIFO and no VGA traffic: 1 DRAIN cycle + 1024 writes.
- **Starvation:** continuous iVgaRdEn starves the FIFO and the fill. Scan-out blanking intervals guarantee progress; the arbiter does no aging.
- **Reset mid-operation** drops queued writes and aborts a fill. RAM keeps the partial contents.

## Configuration
- **VRAM_FILL_EN defined:** the fill FSM, counter, and colour register are built as described above.
- **VRAM_FILL_EN undefined:**
  - iFillStart and iFillColor are ignored.
  - oFillBusy is tied to 0.
  - oCpuBusy = FIFO full only.
  - Only VGA and FIFO grants exist.

## Test plan
- **Write-through:** reset, push (addr 0x013, CYAN) with iVgaRdEn=0. Expect oRamWrEn=1, oRamAddr=0x013, data CYAN the next cycle. Expect oCpuBusy=0 throughout.
- **VGA preemption:** push 4 writes while iVgaRdEn=1 for 6 cycles.
  - oCpuBusy=1 after the 4th push; a 5th request is ignored.
  - oVgaRdValid follows iVgaRdEn delayed by 1 cycle.
  - The 4 writes drain in order on cycles 7–10.
- **Same-address ordering:** push 0x3FF←RED then 0x3FF←GREEN. RAM model reads GREEN at 0x3FF.
- **Fill:** with 2 queued writes, assert iFillStart with iFillColor=BLUE.
  - The FIFO drains first; oFillBusy=1.
  - 1024 writes cover 0x000–0x3FF in ascending order, then oFillBusy=0.
  - Every RAM cell reads BLUE.
- **Reset mid-fill:** assert Reset at fill address 0x200. The next cycle shows all reset values. Cells 0x000–0x1FF are BLUE; the rest are unchanged.
- **Macro off:** build without VRAM_FILL_EN and pulse iFillStart. No RAM writes occur; oFillBusy stays 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port video-RAM arbiter. Priority order: VGA scan-out fetch, then the CPU write FIFO, then the fill engine.
// Define VRAM_FILL_EN to build the hardware fill engine. When it is undefined, only VGA and FIFO grants exist.
`timescale 1ns/1ps
module vram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iCpuWrEn,
    input  logic [ADDR_W-1:0] iCpuWrAddr,
    input  logic [DATA_W-1:0] iCpuWrData,
    output logic              oCpuBusy,
    input  logic              iVgaRdEn,
    input  logic [ADDR_W-1:0] iVgaRdAddr,
    output logic [DATA_W-1:0] oVgaRdData,
    output logic              oVgaRdValid,
    input  logic              iFillStart,
    input  logic [DATA_W-1:0] iFillColor,
    output logic              oFillBusy,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic              oRamWrEn,
    output logic [DATA_W-1:0] oRamWrData,
    input  logic [DATA_W-1:0] iRamRdData
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               vgaValid_q;

    logic               fifoFull;
    logic               fifoEmpty;
    logic               push;
    logic               pop;
    logic               fifoGnt;
    logic               fillGnt;
    logic               fillBusy;
    logic [ADDR_W-1:0]  fillAddr;
    logic [DATA_W-1:0]  fillColor;
    logic [ADDR_W-1:0]  headAddr;
    logic [DATA_W-1:0]  headData;

    assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign oCpuBusy  = fifoFull || fillBusy;
    assign oFillBusy = fillBusy;
    assign push      = iCpuWrEn && !oCpuBusy;
    assign fifoGnt   = !iVgaRdEn && !fifoEmpty;
    assign pop       = fifoGnt;
    assign {headAddr, headData} = fifoMem_q[rdPtr_q];

    assign oVgaRdData  = iRamRdData;
    assign oVgaRdValid = vgaValid_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            vgaValid_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            vgaValid_q <= iVgaRdEn;
        end
    end

    // Storage needs no reset: the pointers and count alone decide what is queued.
    always_ff @(posedge Clock) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {iCpuWrAddr, iCpuWrData};
        end
    end

    always_comb begin
        oRamAddr   = '0;
        oRamWrEn   = 1'b0;
        oRamWrData = '0;
        if (iVgaRdEn) begin
            oRamAddr = iVgaRdAddr;
        end else if (fifoGnt) begin
            oRamAddr   = headAddr;
            oRamWrEn   = 1'b1;
            oRamWrData = headData;
        end else if (fillGnt) begin
            oRamAddr   = fillAddr;
            oRamWrEn   = 1'b1;
            oRamWrData = fillColor;
        end
    end

`ifdef VRAM_FILL_EN
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fillAddr_q, fillAddr_d;
    logic [DATA_W-1:0] fillColor_q, fillColor_d;

    assign fillBusy  = (state_q != ST_IDLE);
    assign fillGnt   = (state_q == ST_FILL) && !iVgaRdEn && fifoEmpty;
    assign fillAddr  = fillAddr_q;
    assign fillColor = fillColor_q;

    // The fill ends after the write to the last address, when the counter wraps to zero.
    always_comb begin
        state_d     = state_q;
        fillAddr_d  = fillAddr_q;
        fillColor_d = fillColor_q;
        case (state_q)
            ST_IDLE: begin
                if (iFillStart) begin
                    fillColor_d = iFillColor;
                    fillAddr_d  = '0;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifoEmpty) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fillGnt) begin
                    fillAddr_d = fillAddr_q + 1'b1;
                    if (fillAddr_q == {ADDR_W{1'b1}}) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            fillAddr_q  <= '0;
            fillColor_q <= '0;
        end else begin
            state_q     <= state_d;
            fillAddr_q  <= fillAddr_d;
            fillColor_q <= fillColor_d;
        end
    end
`else
    logic unusedFill;

    assign unusedFill = ^{iFillStart, iFillColor};
    assign fillBusy   = 1'b0;
    assign fillGnt    = 1'b0;
    assign fillAddr   = '0;
    assign fillColor  = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a behavioural 1024x3 RAM.
// The fill scenarios are exercised when VRAM_FILL_EN is defined, and the disabled-fill scenario otherwise.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] CYAN  = 3'b011;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iCpuWrEn;
    logic [9:0] iCpuWrAddr;
    logic [2:0] iCpuWrData;
    logic       oCpuBusy;
    logic       iVgaRdEn;
    logic [9:0] iVgaRdAddr;
    logic [2:0] oVgaRdData;
    logic       oVgaRdValid;
    logic       iFillStart;
    logic [2:0] iFillColor;
    logic       oFillBusy;
    logic [9:0] oRamAddr;
    logic       oRamWrEn;
    logic [2:0] oRamWrData;
    logic [2:0] iRamRdData;

    logic [2:0] ram [1024];
    logic [2:0] preemptData [4];
    int errCount = 0;
    int checkCount = 0;

    vram_arbiter #(.ADDR_W(10), .DATA_W(3), .FIFO_DEPTH(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .iCpuWrEn(iCpuWrEn), .iCpuWrAddr(iCpuWrAddr), .iCpuWrData(iCpuWrData), .oCpuBusy(oCpuBusy),
        .iVgaRdEn(iVgaRdEn), .iVgaRdAddr(iVgaRdAddr), .oVgaRdData(oVgaRdData), .oVgaRdValid(oVgaRdValid),
        .iFillStart(iFillStart), .iFillColor(iFillColor), .oFillBusy(oFillBusy),
        .oRamAddr(oRamAddr), .oRamWrEn(oRamWrEn), .oRamWrData(oRamWrData), .iRamRdData(iRamRdData)
    );

    always #5 Clock = ~Clock;

    // Synchronous-read RAM: data for an address appears one cycle later.
    always @(posedge Clock) begin
        iRamRdData <= ram[oRamAddr];
        if (oRamWrEn) ram[oRamAddr] <= oRamWrData;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset;
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkCount++; if (oCpuBusy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_cpubusy: got %b expected 0", oCpuBusy); end
        checkCount++; if (oFillBusy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_fillbusy: got %b expected 0", oFillBusy); end
        checkCount++; if (oVgaRdValid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_vgavalid: got %b expected 0", oVgaRdValid); end
        checkCount++; if (oRamWrEn !== 1'b0) begin errCount++; $display("[TB] FAIL reset_wren: got %b expected 0", oRamWrEn); end
        checkCount++; if (oRamAddr !== 10'h000) begin errCount++; $display("[TB] FAIL reset_addr: got %h expected 000", oRamAddr); end
    endtask

    task automatic test_write_through;
        @(negedge Clock);
        iCpuWrEn = 1'b1; iCpuWrAddr = 10'h013; iCpuWrData = CYAN;
        #1;
        checkCount++; if (oCpuBusy !== 1'b0) begin errCount++; $display("[TB] FAIL wt_busy_push: got %b expected 0", oCpuBusy); end
        checkCount++; if (oRamWrEn !== 1'b0) begin errCount++; $display("[TB] FAIL wt_early_wren: got %b expected 0", oRamWrEn); end
        @(negedge Clock);
        iCpuWrEn = 1'b0;
        #1;
        checkCount++; if (oRamWrEn !== 1'b1) begin errCount++; $display("[TB] FAIL wt_wren: got %b expected 1", oRamWrEn); end
        checkCount++; if (oRamAddr !== 10'h013) begin errCount++; $display("[TB] FAIL wt_addr: got %h expected 013", oRamAddr); end
        checkCount++; if (oRamWrData !== CYAN) begin errCount++; $display("[TB] FAIL wt_data: got %h expected %h", oRamWrData, CYAN); end
        checkCount++; if (oCpuBusy !== 1'b0) begin errCount++; $display("[TB] FAIL wt_busy_after: got %b expected 0", oCpuBusy); end
        @(negedge Clock);
        #1;
        checkCount++; if (oRamWrEn !== 1'b0) begin errCount++; $display("[TB] FAIL wt_idle_wren: got %b expected 0", oRamWrEn); end
    endtask

    // Cycles 1-6 read with VGA; pushes in cycles 1-5, the fifth must be dropped because the FIFO is full.
    task automatic test_vga_preempt;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clock);
            iVgaRdEn   = (c <= 6);
            iVgaRdAddr = 10'h013;
            iCpuWrEn   = (c <= 5);
            iCpuWrAddr = 10'h020 + 10'(c - 1);
            iCpuWrData = (c <= 4) ? preemptData[c - 1] : WHITE;
            #1;
            checkCount++;
            if (oVgaRdValid !== ((c >= 2) && (c <= 7))) begin
                errCount++; $display("[TB] FAIL pre_valid_c%0d: got %b expected %b", c, oVgaRdValid, ((c >= 2) && (c <= 7)));
            end
            if (c <= 6) begin
                checkCount++; if (oRamWrEn !== 1'b0) begin errCount++; $display("[TB] FAIL pre_vga_wren_c%0d: got %b expected 0", c, oRamWrEn); end
                checkCount++; if (oRamAddr !== 10'h013) begin errCount++; $display("[TB] FAIL pre_vga_addr_c%0d: got %h expected 013", c, oRamAddr); end
            end
            if (c <= 4) begin
                checkCount++; if (oCpuBusy !== 1'b0) begin errCount++; $display("[TB] FAIL pre_busy_c%0d: got %b expected 0", c, oCpuBusy); end
            end
            if (c == 2) begin
                checkCount++; if (oVgaRdData !== CYAN) begin errCount++; $display("[TB] FAIL pre_rddata: got %h expected %h", oVgaRdData, CYAN); end
            end
            if ((c >= 5) && (c <= 7)) begin
                checkCount++; if (oCpuBusy !== 1'b1) begin errCount++; $display("[TB] FAIL pre_full_c%0d: got %b expected 1", c, oCpuBusy); end
            end
            if ((c >= 7) && (c <= 10)) begin
                checkCount++; if (oRamWrEn !== 1'b1) begin errCount++; $display("[TB] FAIL pre_drain_wren_c%0d: got %b expected 1", c, oRamWrEn); end
                checkCount++; if (oRamAddr !== 10'h020 + 10'(c - 7)) begin errCount++; $display("[TB] FAIL pre_drain_addr_c%0d: got %h expected %h", c, oRamAddr, 10'h020 + 10'(c - 7)); end
                checkCount++; if (oRamWrData !== preemptData[c - 7]) begin errCount++; $display("[TB] FAIL pre_drain_data_c%0d: got %h expected %h", c, oRamWrData, preemptData[c - 7]); end
            end
            if (c == 8) begin
                checkCount++; if (oCpuBusy !== 1'b0) begin errCount++; $display("[TB] FAIL pre_busy_fall: got %b expected 0", oCpuBusy); end
            end
            if (c >= 11) begin
                checkCount++; if (oRamWrEn !== 1'b0) begin errCount++; $display("[TB] FAIL pre_fifth_dropped_c%0d: got %b expected 0", c, oRamWrEn); end
            end
        end
        iCpuWrEn = 1'b0;
        checkCount++; if (ram[10'h024] !== BLACK) begin errCount++; $display("[TB] FAIL pre_fifth_ram: got %h expected %h", ram[10'h024], BLACK); end
    endtask

    task automatic test_same_addr;
        @(negedge Clock);
        iCpuWrEn = 1'b1; iCpuWrAddr = 10'h3FF; iCpuWrData = RED;
        @(negedge Clock);
        iCpuWrData = GREEN;
        @(negedge Clock);
        iCpuWrEn = 1'b0;
        @(negedge Clock);
        iVgaRdEn = 1'b1; iVgaRdAddr = 10'h3FF;
        @(negedge Clock);
        iVgaRdEn = 1'b0;
        #1;
        checkCount++; if (oVgaRdValid !== 1'b1) begin errCount++; $display("[TB] FAIL same_valid: got %b expected 1", oVgaRdValid); end
        checkCount++; if (oVgaRdData !== GREEN) begin errCount++; $display("[TB] FAIL same_rddata: got %h expected %h", oVgaRdData, GREEN); end
        checkCount++; if (ram[10'h3FF] !== GREEN) begin errCount++; $display("[TB] FAIL same_ram: got %h expected %h", ram[10'h3FF], GREEN); end
    endtask

`ifdef VRAM_FILL_EN
    // Two writes held back by VGA traffic, then a fill request; the FIFO must drain before the sweep.
    task automatic test_fill;
        int badWrites;
        @(negedge Clock);
        iVgaRdEn = 1'b1; iVgaRdAddr = 10'h000;
        iCpuWrEn = 1'b1; iCpuWrAddr = 10'h100; iCpuWrData = RED;
        @(negedge Clock);
        iCpuWrAddr = 10'h101; iCpuWrData = GREEN;
        @(negedge Clock);
        iCpuWrEn = 1'b0; iFillStart = 1'b1; iFillColor = BLUE;
        #1;
        checkCount++; if (oFillBusy !== 1'b0) begin errCount++; $display("[TB] FAIL fill_busy_early: got %b expected 0", oFillBusy); end
        @(negedge Clock);
        iFillStart = 1'b0; iFillColor = RED; iVgaRdEn = 1'b0;
        #1;
        checkCount++; if (oFillBusy !== 1'b1) begin errCount++; $display("[TB] FAIL fill_busy_rise: got %b expected 1", oFillBusy); end
        checkCount++; if (oCpuBusy !== 1'b1) begin errCount++; $display("[TB] FAIL fill_cpubusy: got %b expected 1", oCpuBusy); end
        checkCount++; if (oRamAddr !== 10'h100 || oRamWrEn !== 1'b1) begin errCount++; $display("[TB] FAIL fill_drain0: got %h/%b expected 100/1", oRamAddr, oRamWrEn); end
        @(negedge Clock);
        #1;
        checkCount++; if (oRamAddr !== 10'h101 || oRamWrData !== GREEN) begin errCount++; $display("[TB] FAIL fill_drain1: got %h/%h expected 101/%h", oRamAddr, oRamWrData, GREEN); end
        @(negedge Clock);
        #1;
        checkCount++; if (oRamWrEn !== 1'b0) begin errCount++; $display("[TB] FAIL fill_drain_gap: got %b expected 0", oRamWrEn); end
        badWrites = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge Clock);
            #1;
            if (oRamWrEn !== 1'b1 || oRamAddr !== 10'(i) || oRamWrData !== BLUE || oFillBusy !== 1'b1) badWrites++;
        end
        checkCount++; if (badWrites !== 0) begin errCount++; $display("[TB] FAIL fill_sweep: got %0d bad cycles expected 0", badWrites); end
        @(negedge Clock);
        #1;
        checkCount++; if (oFillBusy !== 1'b0) begin errCount++; $display("[TB] FAIL fill_busy_fall: got %b expected 0", oFillBusy); end
        checkCount++; if (oRamWrEn !== 1'b0) begin errCount++; $display("[TB] FAIL fill_after_wren: got %b expected 0", oRamWrEn); end
        badWrites = 0;
        for (int a = 0; a < 1024; a++) if (ram[a] !== BLUE) badWrites++;
        checkCount++; if (badWrites !== 0) begin errCount++; $display("[TB] FAIL fill_ram: got %0d non-blue cells expected 0", badWrites); end
    endtask

    // VGA takes the port in the reset cycle so the write to 0x200 never happens.
    task automatic test_fill_reset;
        int badCells;
        bit seen;
        for (int a = 0; a < 1024; a++) ram[a] = BLACK;
        @(negedge Clock);
        iFillStart = 1'b1; iFillColor = BLUE;
        @(negedge Clock);
        iFillStart = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge Clock);
            #1;
            if (oRamWrEn === 1'b1 && oRamAddr === 10'h1FF) seen = 1'b1;
        end
        checkCount++; if (!seen) begin errCount++; $display("[TB] FAIL rst_reach_1ff: got timeout expected write to 1FF"); end
        @(negedge Clock);
        Reset = 1'b1; iVgaRdEn = 1'b1; iVgaRdAddr = 10'h000;
        @(negedge Clock);
        Reset = 1'b0; iVgaRdEn = 1'b0;
        #1;
        checkCount++; if (oFillBusy !== 1'b0) begin errCount++; $display("[TB] FAIL rst_fillbusy: got %b expected 0", oFillBusy); end
        checkCount++; if (oCpuBusy !== 1'b0) begin errCount++; $display("[TB] FAIL rst_cpubusy: got %b expected 0", oCpuBusy); end
        checkCount++; if (oVgaRdValid !== 1'b0) begin errCount++; $display("[TB] FAIL rst_valid: got %b expected 0", oVgaRdValid); end
        checkCount++; if (oRamWrEn !== 1'b0) begin errCount++; $display("[TB] FAIL rst_wren: got %b expected 0", oRamWrEn); end
        badCells = 0;
        for (int a = 0; a < 1024; a++) if (ram[a] !== ((a < 512) ? BLUE : BLACK)) badCells++;
        checkCount++; if (badCells !== 0) begin errCount++; $display("[TB] FAIL rst_partial_ram: got %0d wrong cells expected 0", badCells); end
    endtask
`else
    task automatic test_fill_disabled;
        int badCycles;
        @(negedge Clock);
        iFillStart = 1'b1; iFillColor = BLUE;
        @(negedge Clock);
        iFillStart = 1'b0;
        badCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            #1;
            checkCount++; if (oFillBusy !== 1'b0) begin errCount++; $display("[TB] FAIL off_fillbusy_%0d: got %b expected 0", i, oFillBusy); end
            if (oRamWrEn !== 1'b0 || oCpuBusy !== 1'b0) badCycles++;
        end
        checkCount++; if (badCycles !== 0) begin errCount++; $display("[TB] FAIL off_no_writes: got %0d bad cycles expected 0", badCycles); end
        checkCount++; if (ram[10'h000] !== BLACK) begin errCount++; $display("[TB] FAIL off_ram0: got %h expected %h", ram[10'h000], BLACK); end
        checkCount++; if (ram[10'h3FF] !== GREEN) begin errCount++; $display("[TB] FAIL off_ram3ff: got %h expected %h", ram[10'h3FF], GREEN); end
    endtask
`endif

    initial begin
        for (int a = 0; a < 1024; a++) ram[a] = BLACK;
        preemptData[0] = RED; preemptData[1] = GREEN; preemptData[2] = BLUE; preemptData[3] = CYAN;
        Reset = 1'b1;
        iCpuWrEn = 1'b0; iCpuWrAddr = '0; iCpuWrData = '0;
        iVgaRdEn = 1'b0; iVgaRdAddr = '0;
        iFillStart = 1'b0; iFillColor = '0;
        test_reset();
        test_write_through();
        test_vga_preempt();
        test_same_addr();
`ifdef VRAM_FILL_EN
        test_fill();
        test_fill_reset();
`else
        test_fill_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
